key_cmd_encoder: RTL and testbench

//  Transmit-side counterpart of the UART LED-control command parser. Watches NUM_KEYS

---
 rtl/key_cmd_pkg.sv | 20 ++
 rtl/key_debounce.sv | 72 +++++++
 rtl/key_cmd_encoder.sv | 127 ++++++++++++
 tb/tb_key_cmd_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_pkg.sv
// rtl/key_cmd_pkg.sv - frame byte constants and FSM states shared by the key command encoder and parser
package key_cmd_pkg;

    localparam logic [7:0] ID_BASE  = 8'hB0;
    localparam logic [7:0] VAL_ON   = 8'hFF;
    localparam logic [7:0] VAL_OFF  = 8'h00;
    localparam logic [7:0] END_BYTE = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_ID,
        ST_SEND_VAL,
        ST_SEND_END
    } key_cmd_state_e;

    function automatic logic [7:0] id_byte(input logic [3:0] idx);
        return ID_BASE + {4'h0, idx};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key 2-flop synchroniser with optional stability counter (KEY_DEBOUNCE_EN)
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_stable
);

`ifdef KEY_DEBOUNCE_EN
    localparam bit USE_COUNTER = (DEBOUNCE_CYCLES > 0);
`else
    localparam bit USE_COUNTER = (DEBOUNCE_CYCLES > 0) && 1'b0;
`endif

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        if (USE_COUNTER) begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          stable_q, stable_d;

            // Counter only runs while the synchronised level disagrees with the accepted one.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (sync2_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign key_stable = stable_q;
        end else begin : g_bypass
            assign key_stable = sync2_q;
        end
    endgenerate

endmodule

// File: rtl/key_cmd_encoder.sv
// rtl/key_cmd_encoder.sv - turns key level changes into ID/value/terminator byte frames; KEY_DEBOUNCE_EN adds debounce
module key_cmd_encoder #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy
);
    import key_cmd_pkg::*;

    logic [NUM_KEYS-1:0] key_stable;
    logic [NUM_KEYS-1:0] pending;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .key_raw   (keys[i]),
            .key_stable(key_stable[i])
        );
    end

    key_cmd_state_e      state_q, state_d;
    logic [NUM_KEYS-1:0] sent_state_q, sent_state_d;
    logic [3:0]          idx_q, idx_d;
    logic                val_q, val_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;

    logic [3:0]          sel_idx;
    logic                sel_val;
    logic                accept;

    assign pending = key_stable ^ sent_state_q;
    assign accept  = tx_valid_q && tx_ready;

    // Descending scan so the lowest pending index is the one left standing.
    always_comb begin
        sel_idx = '0;
        sel_val = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = 4'(i);
                sel_val = key_stable[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sent_state_d = sent_state_q;
        idx_d        = idx_q;
        val_d        = val_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                if (|pending) begin
                    idx_d      = sel_idx;
                    val_d      = sel_val;
                    tx_data_d  = id_byte(sel_idx);
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND_ID;
                end
            end
            ST_SEND_ID: begin
                if (accept) begin
                    tx_data_d = val_q ? VAL_ON : VAL_OFF;
                    state_d   = ST_SEND_VAL;
                end
            end
            ST_SEND_VAL: begin
                if (accept) begin
                    tx_data_d = END_BYTE;
                    state_d   = ST_SEND_END;
                end
            end
            ST_SEND_END: begin
                if (accept) begin
                    // The latched level is recorded, not the live one: a later change re-enters via pending.
                    for (int i = 0; i < NUM_KEYS; i++) begin
                        if (4'(i) == idx_q) begin
                            sent_state_d[i] = val_q;
                        end
                    end
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sent_state_q <= '0;
            idx_q        <= '0;
            val_q        <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sent_state_q <= sent_state_d;
            idx_q        <= idx_d;
            val_q        <= val_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_cmd_encoder.sv
// tb/tb_key_cmd_encoder.sv - directed and randomized checks of key_cmd_encoder frames against a frame-level model
module tb_key_cmd_encoder;

    localparam int NK = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int LAT = 3 + 8;
`else
    localparam int LAT = 3;
`endif

    logic          clk;
    logic          reset;
    logic [NK-1:0] keys;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int valid_seen = 0;
    bit rand_ready = 0;

    logic [7:0] byte_q[$];
    int         acc_q[$];
    logic [7:0] exp_q[$];

    logic          prev_stall = 1'b0;
    logic [7:0]    prev_data  = 8'h00;
    logic [NK-1:0] model_sent;

    key_cmd_encoder #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .keys    (keys),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte monitor: captures accepted bytes and enforces hold-while-stalled.
    always @(negedge clk) begin
        if (cyc > 2) check("busy_vs_valid", 32'(busy), 32'(tx_valid));
        if (prev_stall && !reset) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_data", 32'(tx_data), 32'(prev_data));
        end
        if (!reset && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            byte_q.push_back(tx_data);
            acc_q.push_back(cyc);
        end
        if (tx_valid === 1'b1) valid_seen++;
        prev_stall = (tx_valid === 1'b1) && (tx_ready === 1'b0) && !reset;
        prev_data  = tx_data;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic set_keys(input logic [NK-1:0] k);
        @(posedge clk);
        #1;
        keys = k;
    endtask

    task automatic push_frame(input int idx, input bit val);
        exp_q.push_back(8'hB0 + 8'(idx));
        exp_q.push_back(val ? 8'hFF : 8'h00);
        exp_q.push_back(8'hAA);
    endtask

    task automatic clear_all();
        byte_q.delete();
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic run_expect(input string tag, input int budget);
        int k = 0;
        logic [31:0] got;
        while (byte_q.size() < exp_q.size() && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (12) @(negedge clk);
        check({tag, "_len"}, 32'(byte_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < byte_q.size()) ? 32'(byte_q[i]) : 32'hDEAD_BEEF;
            check($sformatf("%s_b%0d", tag, i), got, 32'(exp_q[i]));
        end
    endtask

    task automatic wait_offer(input string tag, input logic [7:0] b);
        int k = 0;
        while (!(tx_valid === 1'b1 && tx_data === b) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_offer"}, 32'(tx_data), 32'(b));
    endtask

    initial begin
        reset    = 1'b1;
        keys     = '0;
        tx_ready = 1'b1;

        // 1: reset state and quiet keys
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(tx_data), 32'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("t1_no_valid", 32'(valid_seen), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: single key on, latency and back-to-back bytes
        clear_all();
        set_keys(4'b0100);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check($sformatf("t2_lat_low%0d", i), 32'(tx_valid), 32'd0);
        end
        @(negedge clk);
        check("t2_lat_high", 32'(tx_valid), 32'd1);
        push_frame(2, 1);
        run_expect("t2", 100);
        if (acc_q.size() >= 3) begin
            check("t2_gap01", 32'(acc_q[1] - acc_q[0]), 32'd1);
            check("t2_gap12", 32'(acc_q[2] - acc_q[1]), 32'd1);
        end
        check("t2_idle", 32'(tx_valid), 32'd0);

        // 3: simultaneous changes, ascending order, one idle cycle between frames
        clear_all();
        set_keys(4'b0000);
        push_frame(2, 0);
        run_expect("t3a", 100);
        clear_all();
        set_keys(4'b1011);
        push_frame(0, 1);
        push_frame(1, 1);
        push_frame(3, 1);
        run_expect("t3", 200);
        if (acc_q.size() >= 9) begin
            check("t3_in_frame", 32'(acc_q[2] - acc_q[0]), 32'd2);
            check("t3_gap_a", 32'(acc_q[3] - acc_q[2]), 32'd2);
            check("t3_gap_b", 32'(acc_q[6] - acc_q[5]), 32'd2);
        end

        // 4: receiver stall while value byte is offered
        clear_all();
        tx_ready = 1'b0;
        set_keys(4'b1111);
        wait_offer("t4_id", 8'hB2);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold_data%0d", i), 32'(tx_data), 32'hFF);
            check($sformatf("t4_hold_valid%0d", i), 32'(tx_valid), 32'd1);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        push_frame(2, 1);
        run_expect("t4", 100);

        // 5: key drops while its frame is in SEND_VAL
        clear_all();
        set_keys(4'b1110);
        push_frame(0, 0);
        run_expect("t5a", 100);
        clear_all();
        set_keys(4'b1111);
        wait_offer("t5_val", 8'hFF);
        keys = 4'b1110;
        push_frame(0, 1);
        push_frame(0, 0);
        run_expect("t5", 200);

        // 6: reset mid-frame, key still high is re-sent afterwards
        @(posedge clk);
        #1;
        keys  = 4'b0000;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        clear_all();
        run_expect("t6_quiet", 50);
        set_keys(4'b0010);
        wait_offer("t6_val", 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_data", 32'(tx_data), 32'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_all();
        push_frame(1, 1);
        run_expect("t6", 200);

`ifdef KEY_DEBOUNCE_EN
        clear_all();
        set_keys(4'b0110);
        repeat (5) @(posedge clk);
        #1 keys = 4'b0010;
        repeat (40) @(posedge clk);
        run_expect("t6_glitch", 10);
`endif

        // Randomized key vectors with random back-pressure; model is one frame per changed key, ascending.
        model_sent = 4'b0010;
        rand_ready = 1'b1;
        for (int it = 0; it < 16; it++) begin
            logic [NK-1:0] nk;
            nk = NK'($urandom_range(0, (1 << NK) - 1));
            clear_all();
            set_keys(nk);
            for (int i = 0; i < NK; i++) begin
                if (nk[i] != model_sent[i]) push_frame(i, nk[i]);
            end
            run_expect($sformatf("rnd%0d", it), 600);
            model_sent = nk;
        end
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
